bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-add-3 (double dabble), one input bit per clock.
// Digits beyond DIGITS are discarded; o_ovf flags that the value did not fit.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               valid_q, valid_d;
  logic               ovf_out_q, ovf_out_d;
  logic [BCD_W-1:0]   adj;

  // Pre-shift correction: any digit >= 5 would become >= 10 after doubling.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    ovf_out_d = ovf_out_q;
    adj       = add3(work_q);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          sh_d    = i_bin;
          work_d  = '0;
          cnt_d   = CNT_W'(WIDTH);
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The bit leaving the top kept digit belongs to a discarded digit.
        ovf_d  = ovf_q | adj[BCD_W-1];
        work_d = {adj[BCD_W-2:0], sh_q[WIDTH-1]};
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d     = work_q;
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_bcd   = bcd_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_out_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 16-bit/5-digit and 8-bit/2-digit instances, table vectors,
// random values against a decimal reference model, and multi-cycle corner sequences.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1, start = 1'b0;
  logic [15:0] bin = '0;
  logic [19:0] bcd;
  logic        valid, busy, ovf;

  logic        rst2_n = 1'b1, start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic [7:0]  bcd2;
  logic        valid2, busy2, ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bin(bin),
    .o_bcd(bcd), .o_valid(valid), .o_busy(busy), .o_ovf(ovf));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_start(start2), .i_bin(bin2),
    .o_bcd(bcd2), .o_valid(valid2), .o_busy(busy2), .o_ovf(ovf2));

  // Reference: decimal digits by repeated division, overflow by magnitude.
  function automatic logic [27:0] mdl_bcd(input int unsigned v, input int digits);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic mdl_ovf(input int unsigned v, input int digits);
    int unsigned p;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    return v >= p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run1(input logic [15:0] v, input logic [19:0] exp_bcd, input logic exp_ovf);
    int k, busy_n;
    logic got;
    @(negedge clk); bin = v; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; bin = 16'($urandom);
    k = 0; busy_n = 0; got = 1'b0;
    while (k < 60 && !got) begin
      if (valid) got = 1'b1;
      else begin
        if (busy) busy_n++;
        @(posedge clk); #1; k++;
      end
    end
    chk("latency16", k, 17);
    chk("busy_cycles16", busy_n, 17);
    chk("busy_at_valid16", busy, 0);
    chk("bcd16", bcd, exp_bcd);
    chk("ovf16", ovf, exp_ovf);
    @(posedge clk); #1;
    chk("valid_pulse16", valid, 0);
    chk("bcd_hold16", bcd, exp_bcd);
  endtask

  task automatic run2(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf);
    int k, busy_n;
    logic got;
    @(negedge clk); bin2 = v; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0; bin2 = 8'($urandom);
    k = 0; busy_n = 0; got = 1'b0;
    while (k < 40 && !got) begin
      if (valid2) got = 1'b1;
      else begin
        if (busy2) busy_n++;
        @(posedge clk); #1; k++;
      end
    end
    chk("latency8", k, 9);
    chk("busy_cycles8", busy_n, 9);
    chk("bcd8", bcd2, exp_bcd);
    chk("ovf8", ovf2, exp_ovf);
  endtask

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec16_t;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] bcd;
    logic       ovf;
  } vec8_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec16_t t16[10];
    vec8_t  t8[4];
    logic [27:0] m;
    int unsigned v;
    int k, np, first;
    logic [19:0] cap;

    t16[0] = '{16'd0,     20'h00000};
    t16[1] = '{16'd65535, 20'h65535};
    t16[2] = '{16'd1234,  20'h01234};
    t16[3] = '{16'd9999,  20'h09999};
    t16[4] = '{16'd4660,  20'h04660};
    t16[5] = '{16'd7,     20'h00007};
    t16[6] = '{16'd10000, 20'h10000};
    t16[7] = '{16'd1,     20'h00001};
    t16[8] = '{16'd59049, 20'h59049};
    t16[9] = '{16'd32768, 20'h32768};
    t8[0]  = '{8'd255, 8'h55, 1'b1};
    t8[1]  = '{8'd99,  8'h99, 1'b0};
    t8[2]  = '{8'd100, 8'h00, 1'b1};
    t8[3]  = '{8'd9,   8'h09, 1'b0};

    // Asynchronous reset with no clock edge in between.
    #1; rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_clk", busy, 0);
    chk("rst_bcd2", bcd2, 0);
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;

    for (int i = 0; i < 10; i++) run1(t16[i].bin, t16[i].bcd, 1'b0);

    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, 65535);
      m = mdl_bcd(v, 5);
      run1(16'(v), m[19:0], mdl_ovf(v, 5));
    end

    for (int i = 0; i < 4; i++) run2(t8[i].bin, t8[i].bcd, t8[i].ovf);
    for (int i = 0; i < 12; i++) begin
      v = $urandom_range(0, 255);
      m = mdl_bcd(v, 2);
      run2(8'(v), m[7:0], mdl_ovf(v, 2));
    end

    // Second start during SHIFT is dropped.
    @(negedge clk); bin = 16'd4660; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); bin = 16'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    np = 0; first = -1; cap = '0;
    for (k = 6; k <= 45; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        np++;
        if (first < 0) begin first = k; cap = bcd; end
      end
    end
    chk("ignore_pulses", np, 1);
    chk("ignore_latency", first, 17);
    chk("ignore_bcd", cap, 20'h04660);

    // Start held high: back-to-back conversions every 18 cycles.
    @(negedge clk); bin = 16'd42; start = 1'b1;
    @(posedge clk); #1;
    np = 0;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        chk("held_period", k, 17 + 18 * np);
        chk("held_bcd", bcd, 20'h00042);
        np++;
      end
    end
    chk("held_pulses", np, 3);
    @(negedge clk); start = 1'b0;
    k = 0;
    while (busy && k < 40) begin @(posedge clk); #1; k++; end
    chk("held_drain", busy, 0);
    @(posedge clk); #1;

    // Reset in the middle of a conversion aborts it.
    @(negedge clk); bin = 16'd65535; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_valid", valid, 0);
    @(posedge clk); #1;
    chk("abort_busy_clk", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    np = 0;
    for (k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (valid) np++;
    end
    chk("abort_no_valid", np, 0);
    run1(16'd7, 20'h00007, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
